// File: rtl/board_vga_renderer_pkg.sv
// Shared raster constants, types and helpers for the board VGA renderer.
// Defaults describe 640x480 @ 60 Hz with a 25 MHz pixel rate.
package board_vga_renderer_pkg;

   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   typedef logic [11:0] rgb_t;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
   } pos_t;

   // lo <= p < lo+len
   function automatic logic in_span(input logic [9:0] p,
                                    input int lo,
                                    input int len);
      int pi;
      pi = int'({22'd0, p});
      return (pi >= lo) && (pi < lo + len);
   endfunction

endpackage

// File: rtl/board_vga_renderer_if.sv
// VGA output bus: 4-bit r/g/b plus active-low syncs.
// master drives the port, slave observes it.
interface board_vga_renderer_if;

   logic [3:0] vga_r;
   logic [3:0] vga_g;
   logic [3:0] vga_b;
   logic       vga_hs;
   logic       vga_vs;

   modport master (
      output vga_r, vga_g, vga_b, vga_hs, vga_vs
   );

   modport slave (
      input vga_r, vga_g, vga_b, vga_hs, vga_vs
   );

endinterface

// File: rtl/board_vga_renderer_sync.sv
// Raster timing: pixel prescaler, h/v counters, raw syncs.
// Ports: clk, reset_n in; tick_o, line_end_o, pos_o, hs_o, vs_o out.
module board_vga_renderer_sync
   import board_vga_renderer_pkg::*;
#(
   parameter int PIX_DIV = 4,
   parameter int HVIS    = H_VIS,
   parameter int HFP     = H_FP,
   parameter int HSYNC   = H_SYNC,
   parameter int HBP     = H_BP,
   parameter int VVIS    = V_VIS,
   parameter int VFP     = V_FP,
   parameter int VSYNC   = V_SYNC,
   parameter int VBP     = V_BP
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick_o,
   output logic line_end_o,
   output pos_t pos_o,
   output logic hs_o,
   output logic vs_o
);

   localparam int HTOT = HVIS + HFP + HSYNC + HBP;
   localparam int VTOT = VVIS + VFP + VSYNC + VBP;
   localparam logic [7:0] PRE_MAX = 8'(PIX_DIV - 1);
   localparam logic [9:0] H_MAX   = 10'(HTOT - 1);
   localparam logic [9:0] V_MAX   = 10'(VTOT - 1);

   logic [7:0] pre_q, pre_d;
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;

   always_comb begin
      tick_o     = (pre_q == PRE_MAX);
      line_end_o = tick_o && (h_q == H_MAX);
      pre_d      = tick_o ? '0 : pre_q + 8'd1;
      h_d        = h_q;
      v_d        = v_q;
      if (tick_o) begin
         h_d = line_end_o ? '0 : h_q + 10'd1;
      end
      if (line_end_o) begin
         v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         pre_q <= pre_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   assign pos_o = '{h: h_q, v: v_q};
   assign hs_o  = !in_span(h_q, HVIS + HFP, HSYNC);
   assign vs_o  = !in_span(v_q, VVIS + VFP, VSYNC);

endmodule

// File: rtl/board_vga_renderer.sv
// Renders the 16x16 Life board onto VGA with a per-frame snapshot.
// Ports: clk, reset_n, board_i in; vga (master) bus, frame_o out.
module board_vga_renderer
   import board_vga_renderer_pkg::*;
#(
   parameter int          PIX_DIV   = 4,
   parameter int          CELL_PX   = 24,
   parameter int          X0        = 128,
   parameter int          Y0        = 48,
   parameter int          GRID      = 1,
   parameter logic [11:0] ALIVE_RGB = 12'hFFF,
   parameter logic [11:0] DEAD_RGB  = 12'h000,
   parameter logic [11:0] GRID_RGB  = 12'h444,
   parameter int          HVIS      = H_VIS,
   parameter int          HFP       = H_FP,
   parameter int          HSYNC     = H_SYNC,
   parameter int          HBP       = H_BP,
   parameter int          VVIS      = V_VIS,
   parameter int          VFP       = V_FP,
   parameter int          VSYNC     = V_SYNC,
   parameter int          VBP       = V_BP
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [255:0]         board_i,
   board_vga_renderer_if.master vga,
   output logic                 frame_o
);

   localparam int SPAN = 16 * CELL_PX;
   localparam logic [7:0] SUB_MAX = 8'(CELL_PX - 1);
   localparam logic [9:0] V_LAST  = 10'(VVIS - 1);

   logic tick, line_end, hs_raw, vs_raw;
   pos_t pos;

   logic [7:0]   xs_q, xs_d, ys_q, ys_d;
   logic [3:0]   xc_q, xc_d, yc_q, yc_d;
   logic [255:0] snap_q, snap_d;
   rgb_t         rgb_q, rgb_d;
   logic         hs_q, hs_d, vs_q, vs_d;
   logic         in_x, in_y, vis, snap_en;

   board_vga_renderer_sync #(
      .PIX_DIV (PIX_DIV),
      .HVIS    (HVIS),
      .HFP     (HFP),
      .HSYNC   (HSYNC),
      .HBP     (HBP),
      .VVIS    (VVIS),
      .VFP     (VFP),
      .VSYNC   (VSYNC),
      .VBP     (VBP)
   ) u_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick_o     (tick),
      .line_end_o (line_end),
      .pos_o      (pos),
      .hs_o       (hs_raw),
      .vs_o       (vs_raw)
   );

   always_comb begin
      in_x    = in_span(pos.h, X0, SPAN);
      in_y    = in_span(pos.v, Y0, SPAN);
      vis     = in_span(pos.h, 0, HVIS) && in_span(pos.v, 0, VVIS);
      // last pixel of the final visible line: v becomes VVIS next tick
      snap_en = line_end && (pos.v == V_LAST);

      // cell counters wrap back to 0 on leaving the region
      xs_d = xs_q;
      xc_d = xc_q;
      if (tick && in_x) begin
         if (xs_q == SUB_MAX) begin
            xs_d = '0;
            xc_d = xc_q + 4'd1;
         end else begin
            xs_d = xs_q + 8'd1;
         end
      end

      ys_d = ys_q;
      yc_d = yc_q;
      if (line_end && in_y) begin
         if (ys_q == SUB_MAX) begin
            ys_d = '0;
            yc_d = yc_q + 4'd1;
         end else begin
            ys_d = ys_q + 8'd1;
         end
      end

      snap_d = snap_en ? board_i : snap_q;

      rgb_d = rgb_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      if (tick) begin
         hs_d  = hs_raw;
         vs_d  = vs_raw;
         rgb_d = '0;
         if (vis && in_x && in_y) begin
            if (GRID != 0 && (xs_q == '0 || ys_q == '0)) begin
               rgb_d = GRID_RGB;
            end else if (snap_q[{yc_q, xc_q}]) begin
               rgb_d = ALIVE_RGB;
            end else begin
               rgb_d = DEAD_RGB;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xs_q   <= '0;
         xc_q   <= '0;
         ys_q   <= '0;
         yc_q   <= '0;
         snap_q <= '0;
         rgb_q  <= '0;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
      end else begin
         xs_q   <= xs_d;
         xc_q   <= xc_d;
         ys_q   <= ys_d;
         yc_q   <= yc_d;
         snap_q <= snap_d;
         rgb_q  <= rgb_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
      end
   end

   assign frame_o    = snap_en;
   assign vga.vga_r  = rgb_q[11:8];
   assign vga.vga_g  = rgb_q[7:4];
   assign vga.vga_b  = rgb_q[3:0];
   assign vga.vga_hs = hs_q;
   assign vga.vga_vs = vs_q;

endmodule

// File: tb/tb_board_vga_renderer.sv
// Testbench: shrunken-raster DUT for frame behaviour, default DUT
// for real 640x480 line timing.
module tb_board_vga_renderer;

   localparam int PD = 2;
   localparam int C  = 4;
   localparam int X0 = 10;
   localparam int Y0 = 2;
   localparam int HVIS = 84, HFP = 2, HSYNC = 6, HBP = 4;
   localparam int VVIS = 68, VFP = 2, VSYNC = 2, VBP = 2;
   localparam int HT = HVIS + HFP + HSYNC + HBP;
   localparam int VT = VVIS + VFP + VSYNC + VBP;
   localparam int FR = HT * VT;

   typedef struct {
      int          p;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      string       tag;
   } probe_t;

   typedef struct {
      int          x;
      int          y;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      string       tag;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [255:0] board = '0;
   logic         frame, framed;
   int           cyc;
   int           total = 0;
   int           bad = 0;
   bit           rel = 1'b0;
   bit           ddone = 1'b0;
   probe_t       sb[$];
   int           fq[$];

   board_vga_renderer_if vi();
   board_vga_renderer_if vd();

   board_vga_renderer #(
      .PIX_DIV (PD),
      .CELL_PX (C),
      .X0      (X0),
      .Y0      (Y0),
      .HVIS    (HVIS),
      .HFP     (HFP),
      .HSYNC   (HSYNC),
      .HBP     (HBP),
      .VVIS    (VVIS),
      .VFP     (VFP),
      .VSYNC   (VSYNC),
      .VBP     (VBP)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .board_i (board),
      .vga     (vi),
      .frame_o (frame)
   );

   board_vga_renderer dutd (
      .clk     (clk),
      .reset_n (reset_n),
      .board_i (board),
      .vga     (vd),
      .frame_o (framed)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string n, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, got, exp);
      end
   endtask

   function automatic int pix(int f, int x, int y);
      return f * FR + y * HT + x;
   endfunction

   function automatic int tgt(int p);
      return PD * (p + 1);
   endfunction

   function automatic int snapcyc(int f);
      return PD * (f * FR + VVIS * HT) - 1;
   endfunction

   function automatic logic [11:0] m_rgb(int x, int y, logic [255:0] s);
      int cx, cy;
      if (x >= HVIS || y >= VVIS) return 12'h000;
      if (x < X0 || x >= X0 + 16 * C) return 12'h000;
      if (y < Y0 || y >= Y0 + 16 * C) return 12'h000;
      if ((x - X0) % C == 0 || (y - Y0) % C == 0) return 12'h444;
      cx = (x - X0) / C;
      cy = (y - Y0) / C;
      return s[cy * 16 + cx] ? 12'hFFF : 12'h000;
   endfunction

   function automatic void sb_push(probe_t pr);
      int i;
      i = sb.size();
      while (i > 0 && sb[i-1].p > pr.p) i--;
      sb.insert(i, pr);
   endfunction

   function automatic void push_m(int f, int x, int y,
                                  logic [255:0] s, string tag);
      probe_t pr;
      pr.p   = pix(f, x, y);
      pr.rgb = m_rgb(x, y, s);
      pr.hs  = !(x >= HVIS + HFP && x < HVIS + HFP + HSYNC);
      pr.vs  = !(y >= VVIS + VFP && y < VVIS + VFP + VSYNC);
      pr.tag = tag;
      sb_push(pr);
   endfunction

   task automatic wait_cyc(input int t);
      int g;
      g = 0;
      while (cyc < t && g < 100000) begin
         @(negedge clk);
         g++;
      end
      chk($sformatf("reach cyc %0d", t), 32'(cyc >= t), 32'd1);
   endtask

   // scoreboard: compare each probe on the cycle its pixel is shown
   always @(negedge clk) begin
      probe_t pr;
      while (reset_n && sb.size() > 0 && cyc >= tgt(sb[0].p)) begin
         pr = sb.pop_front();
         if (cyc != tgt(pr.p)) begin
            chk({pr.tag, " missed"}, cyc, tgt(pr.p));
         end else begin
            chk({pr.tag, " rgb"}, {vi.vga_r, vi.vga_g, vi.vga_b}, pr.rgb);
            chk({pr.tag, " hs"}, vi.vga_hs, pr.hs);
            chk({pr.tag, " vs"}, vi.vga_vs, pr.vs);
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && frame) fq.push_back(cyc);
   end

   // default raster: hs falls after pixel 656 is registered
   initial begin
      int f1, f2, r1, nz, g;
      logic prev, cur;
      f1 = -1; f2 = -1; r1 = -1; nz = 0; g = 0;
      prev = 1'b1;
      wait (rel);
      while (cyc <= 6000 && g < 10000) begin
         @(negedge clk);
         g++;
         cur = vd.vga_hs;
         if (prev && !cur) begin
            if (f1 < 0) f1 = cyc;
            else if (f2 < 0) f2 = cyc;
         end
         if (!prev && cur && r1 < 0) r1 = cyc;
         if ({vd.vga_r, vd.vga_g, vd.vga_b} != 12'h000 ||
             framed || !vd.vga_vs) nz++;
         prev = cur;
      end
      chk("def hs first fall", f1, 4 * 657);
      chk("def hs low width", r1 - f1, 384);
      chk("def hs period", f2 - f1, 3200);
      chk("def row0 dark, vs high", nz, 0);
      ddone = 1'b1;
   end

   initial begin
      vec_t tbl[$];
      probe_t pr;

      tbl = '{
         '{11, 3, 12'hFFF, 1'b1, 1'b1, "live cell"},
         '{15, 3, 12'h000, 1'b1, 1'b1, "right nbr"},
         '{10, 2, 12'h444, 1'b1, 1'b1, "grid corner"},
         '{ 9, 2, 12'h000, 1'b1, 1'b1, "left of region"},
         '{12, 6, 12'h444, 1'b1, 1'b1, "grid row"},
         '{11, 7, 12'h000, 1'b1, 1'b1, "cell below"},
         '{73,65, 12'h000, 1'b1, 1'b1, "last cell dead"},
         '{74, 3, 12'h000, 1'b1, 1'b1, "right of region"},
         '{11, 1, 12'h000, 1'b1, 1'b1, "above region"},
         '{86, 3, 12'h000, 1'b0, 1'b1, "hsync start"},
         '{91, 3, 12'h000, 1'b0, 1'b1, "hsync end"},
         '{92, 3, 12'h000, 1'b1, 1'b1, "after hsync"},
         '{11,68, 12'h000, 1'b1, 1'b1, "vblank"},
         '{11,70, 12'h000, 1'b1, 1'b0, "vsync"},
         '{11,72, 12'h000, 1'b1, 1'b1, "after vsync"}
      };

      board = 256'd1;
      repeat (3) @(negedge clk);
      chk("rst rgb", {vi.vga_r, vi.vga_g, vi.vga_b}, 12'h000);
      chk("rst hs", vi.vga_hs, 1'b1);
      chk("rst vs", vi.vga_vs, 1'b1);
      chk("rst frame", frame, 1'b0);
      chk("rst def hs/vs", {vd.vga_hs, vd.vga_vs}, 2'b11);
      reset_n = 1'b1;
      rel = 1'b1;

      // frame 0 still shows the reset snapshot
      push_m(0, 10, 2, '0, "f0 grid");
      push_m(0, 11, 3, '0, "f0 dead");
      push_m(0, 9, 2, '0, "f0 outside");
      push_m(0, 88, 5, '0, "f0 hsync");

      for (int i = 0; i < tbl.size(); i++) begin
         pr.p   = pix(1, tbl[i].x, tbl[i].y);
         pr.rgb = tbl[i].rgb;
         pr.hs  = tbl[i].hs;
         pr.vs  = tbl[i].vs;
         pr.tag = {"f1 ", tbl[i].tag};
         sb_push(pr);
      end

      wait_cyc(tgt(pix(1, 0, 30)));
      board = 256'd1 << 17;

      // the value on the snapshot edge wins; later changes are ignored
      wait_cyc(snapcyc(1));
      chk("frame_o on snap cycle", frame, 1'b1);
      board = 256'd1 << 255;
      @(negedge clk);
      board = 256'd2;

      for (int cy = 0; cy < 16; cy++)
         for (int cx = 0; cx < 16; cx++)
            push_m(2, X0 + cx * C + 2, Y0 + cy * C + 2, 256'd1 << 255,
                   $sformatf("f2 cell %0d,%0d", cx, cy));
      push_m(2, 5, 70, 256'd1 << 255, "f2 vs blank");
      push_m(2, 90, 70, 256'd1 << 255, "f2 hs+vs blank");

      wait_cyc(tgt(pix(2, 0, 20)));
      board = '1;

      wait_cyc(snapcyc(2) + 1);
      for (int cy = 0; cy < 9; cy++)
         for (int cx = 0; cx < 16; cx++)
            push_m(3, X0 + cx * C + 2, Y0 + cy * C + 2, '1,
                   $sformatf("f3 cell %0d,%0d", cx, cy));

      wait_cyc(tgt(pix(3, 20, 40)));
      chk("pre-reset rgb", {vi.vga_r, vi.vga_g, vi.vga_b}, 12'hFFF);
      chk("sb drained", sb.size(), 0);
      chk("frame pulses", fq.size(), 3);
      for (int f = 0; f < 3 && f < fq.size(); f++)
         chk($sformatf("frame pulse %0d", f), fq[f], snapcyc(f));
      fq.delete();

      #2 reset_n = 1'b0;
      #1;
      chk("mid rst rgb", {vi.vga_r, vi.vga_g, vi.vga_b}, 12'h000);
      chk("mid rst hs/vs", {vi.vga_hs, vi.vga_vs}, 2'b11);
      chk("mid rst frame", frame, 1'b0);
      repeat (3) @(negedge clk);
      sb.delete();
      reset_n = 1'b1;

      for (int cy = 0; cy < 4; cy++)
         for (int cx = 0; cx < 16; cx++)
            push_m(0, X0 + cx * C + 2, Y0 + cy * C + 2, '0,
                   $sformatf("rs cell %0d,%0d", cx, cy));
      push_m(0, 10, 2, '0, "rs grid");
      for (int y = 69; y < 73; y++)
         push_m(0, 0, y, '0, $sformatf("rs vs line %0d", y));

      wait_cyc(tgt(pix(0, 0, 72)) + 1);
      chk("rs sb drained", sb.size(), 0);
      chk("rs frame pulses", fq.size(), 1);
      if (fq.size() > 0) chk("rs frame cyc", fq[0], snapcyc(0));
      chk("default check done", 32'(ddone), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
